// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 encodings for the load/store unit and its lane aligner.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } ls_state_t;

   localparam logic [2:0] LS_F3__B  = 3'b000;
   localparam logic [2:0] LS_F3__H  = 3'b001;
   localparam logic [2:0] LS_F3__W  = 3'b010;
   localparam logic [2:0] LS_F3__BU = 3'b100;
   localparam logic [2:0] LS_F3__HU = 3'b101;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane logic: store replication/strobes, load extraction,
// and misalignment / illegal-funct3 detection.
module ls_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic        write_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] load_word_o,
   output logic        fault_o
);

   logic [31:0] rsh;
   logic [15:0] rhalf;

   assign rsh   = rdata_i >> {addr_lo_i, 3'b000};
   assign rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      wdata_o     = 32'd0;
      wstrb_o     = 4'd0;
      load_word_o = 32'd0;
      fault_o     = 1'b0;
      case (funct3_i)
         LS_F3__B: begin
            wdata_o     = {4{store_data_i[7:0]}};
            wstrb_o     = 4'b0001 << addr_lo_i;
            load_word_o = {{24{rsh[7]}}, rsh[7:0]};
         end
         LS_F3__H: begin
            fault_o     = addr_lo_i[0];
            wdata_o     = {2{store_data_i[15:0]}};
            wstrb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            load_word_o = {{16{rhalf[15]}}, rhalf};
         end
         LS_F3__W: begin
            fault_o     = |addr_lo_i;
            wdata_o     = store_data_i;
            wstrb_o     = 4'b1111;
            load_word_o = rdata_i;
         end
         // Unsigned variants exist only for loads.
         LS_F3__BU: begin
            fault_o     = write_i;
            load_word_o = {24'd0, rsh[7:0]};
         end
         LS_F3__HU: begin
            fault_o     = write_i | addr_lo_i[0];
            load_word_o = {16'd0, rhalf};
         end
         default: fault_o = 1'b1;
      endcase
      if (!write_i) begin
         wdata_o = 32'd0;
         wstrb_o = 4'd0;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store engine: latches a request on start, runs one
// req/ready memory transaction, and registers the extended load result.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfsm__ls_start,
   input  logic                  cfsm__ls_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  ls_busy,
   output logic                  ls_done,
   output logic                  ls_fault,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  mem__req,
   output logic                  mem__we,
   output logic [ADDR_WIDTH-1:0] mem__addr,
   output logic [DATA_WIDTH-1:0] mem__wdata,
   output logic [3:0]            mem__wstrb,
   input  logic [DATA_WIDTH-1:0] mem__rdata,
   input  logic                  mem__ready,
   output ls_state_t             dbg_state_o
);

   ls_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            f3_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] sd_q;
   logic [DATA_WIDTH-1:0] load_data_q;

   logic        idle;
   logic        in_req;
   logic [2:0]  f3_s;
   logic        we_s;
   logic [1:0]  addr_lo_s;
   logic [31:0] sd_s;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_wstrb;
   logic [31:0] lane_load;
   logic        lane_fault;

   assign idle   = (state_q == IDLE);
   assign in_req = (state_q == REQ);

   // In IDLE the aligner checks the live request for the fault decision;
   // afterwards it works on the latched copy so request outputs stay stable.
   assign f3_s      = idle ? funct3         : f3_q;
   assign we_s      = idle ? cfsm__ls_write : we_q;
   assign addr_lo_s = idle ? addr[1:0]      : addr_q[1:0];
   assign sd_s      = idle ? store_data     : sd_q;

   ls_lane_align u_lane_align (
      .funct3_i     (f3_s),
      .write_i      (we_s),
      .addr_lo_i    (addr_lo_s),
      .store_data_i (sd_s),
      .rdata_i      (mem__rdata),
      .wdata_o      (lane_wdata),
      .wstrb_o      (lane_wstrb),
      .load_word_o  (lane_load),
      .fault_o      (lane_fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         f3_q        <= 3'd0;
         we_q        <= 1'b0;
         sd_q        <= '0;
         load_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (idle && cfsm__ls_start) begin
            addr_q <= addr;
            f3_q   <= funct3;
            we_q   <= cfsm__ls_write;
            sd_q   <= store_data;
         end
         if (in_req && mem__ready && !we_q) begin
            load_data_q <= lane_load;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfsm__ls_start) state_d = lane_fault ? FAULT : REQ;
         REQ:     if (mem__ready) state_d = DONE;
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ls_busy     = !idle;
   assign ls_done     = (state_q == DONE);
   assign ls_fault    = (state_q == FAULT);
   assign load_data   = load_data_q;
   assign mem__req    = in_req;
   assign mem__we     = in_req & we_q;
   assign mem__addr   = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem__wdata  = in_req ? lane_wdata : '0;
   assign mem__wstrb  = in_req ? lane_wstrb : 4'd0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, faults, wait states,
// mid-request reset and a randomized aligned-access sweep.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfsm__ls_start;
   logic        cfsm__ls_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        ls_busy, ls_done, ls_fault;
   logic [31:0] load_data;
   logic        mem__req, mem__we;
   logic [31:0] mem__addr, mem__wdata;
   logic [3:0]  mem__wstrb;
   logic [31:0] mem__rdata;
   logic        mem__ready;
   ls_state_t   dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   load_store_unit dut (
      .clk            (clk),
      .reset          (reset),
      .cfsm__ls_start (cfsm__ls_start),
      .cfsm__ls_write (cfsm__ls_write),
      .funct3         (funct3),
      .addr           (addr),
      .store_data     (store_data),
      .ls_busy        (ls_busy),
      .ls_done        (ls_done),
      .ls_fault       (ls_fault),
      .load_data      (load_data),
      .mem__req       (mem__req),
      .mem__we        (mem__we),
      .mem__addr      (mem__addr),
      .mem__wdata     (mem__wdata),
      .mem__wstrb     (mem__wstrb),
      .mem__rdata     (mem__rdata),
      .mem__ready     (mem__ready),
      .dbg_state_o    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * a)) & 32'hFF;
      h = (rd >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'b000:  model_load = b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'b001:  model_load = h[15] ? (h | 32'hFFFF_0000) : h;
         3'b100:  model_load = b;
         3'b101:  model_load = h;
         default: model_load = rd;
      endcase
   endfunction

   // One transaction; a second start is optionally thrown in during the wait.
   task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int waits, input logic exp_fault,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                         input logic extra_start);
      logic [31:0] prev_ld;
      logic [31:0] exp_ld;
      prev_ld = load_data;
      cfsm__ls_start = 1'b1;
      cfsm__ls_write = we;
      funct3 = f3;
      addr = a;
      store_data = sd;
      mem__rdata = 32'h0;
      mem__ready = 1'b0;
      tick();
      cfsm__ls_start = 1'b0;
      addr = 32'hFFFF_FFFF;
      store_data = 32'h5555_5555;
      if (exp_fault) begin
         total++;
         if (ls_fault !== 1'b1 || mem__req !== 1'b0)
            $display("FAIL %s fault_pulse: fault=%b req=%b, want fault=1 req=0", name, ls_fault, mem__req);
         if (ls_fault !== 1'b1 || mem__req !== 1'b0) bad++;
         tick();
         total++;
         if (ls_fault !== 1'b0 || dbg_state !== IDLE || mem__req !== 1'b0 || load_data !== prev_ld) begin
            $display("FAIL %s fault_after: fault=%b state=%0d req=%b ld=%h, want 0/IDLE/0/%h",
                     name, ls_fault, dbg_state, mem__req, load_data, prev_ld);
            bad++;
         end
         return;
      end
      if (!we) exp_q.push_back(model_load(f3, a[1:0], rd));
      for (int i = 0; i <= waits; i++) begin
         if (extra_start && i == 1) begin
            cfsm__ls_start = 1'b1;
            cfsm__ls_write = ~we;
            funct3 = 3'b010;
            addr = 32'h0000_8000;
         end else begin
            cfsm__ls_start = 1'b0;
         end
         total++;
         if (mem__req !== 1'b1 || mem__we !== we || mem__addr !== {a[31:2], 2'b00} ||
             mem__wstrb !== exp_wstrb || (we && mem__wdata !== exp_wdata) || ls_busy !== 1'b1 ||
             ls_done !== 1'b0) begin
            $display("FAIL %s req_cyc%0d: req=%b we=%b addr=%h wdata=%h wstrb=%b busy=%b done=%b, want 1/%b/%h/%h/%b/1/0",
                     name, i, mem__req, mem__we, mem__addr, mem__wdata, mem__wstrb, ls_busy, ls_done,
                     we, {a[31:2], 2'b00}, exp_wdata, exp_wstrb);
            bad++;
         end
         mem__rdata = rd;
         mem__ready = (i == waits);
         tick();
      end
      cfsm__ls_start = 1'b0;
      mem__ready = 1'b0;
      mem__rdata = 32'hDEAD_0000;
      total++;
      if (ls_done !== 1'b1 || mem__req !== 1'b0) begin
         $display("FAIL %s done_pulse: done=%b req=%b, want done=1 req=0", name, ls_done, mem__req);
         bad++;
      end
      if (!we) begin
         exp_ld = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
         total++;
         if (load_data !== exp_ld) begin
            $display("FAIL %s load_data: got %h want %h", name, load_data, exp_ld);
            bad++;
         end
      end else begin
         total++;
         if (load_data !== prev_ld) begin
            $display("FAIL %s store_keeps_ld: got %h want %h", name, load_data, prev_ld);
            bad++;
         end
      end
      tick();
      total++;
      if (dbg_state !== IDLE || ls_done !== 1'b0 || ls_busy !== 1'b0) begin
         $display("FAIL %s back_idle: state=%0d done=%b busy=%b", name, dbg_state, ls_done, ls_busy);
         bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cfsm__ls_start = 1'b0;
      cfsm__ls_write = 1'b0;
      funct3 = 3'b000;
      addr = 32'h0;
      store_data = 32'h0;
      mem__rdata = 32'h0;
      mem__ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if (dbg_state !== IDLE || ls_busy !== 1'b0 || ls_done !== 1'b0 || ls_fault !== 1'b0 ||
          load_data !== 32'h0 || mem__req !== 1'b0 || mem__we !== 1'b0 || mem__addr !== 32'h0 ||
          mem__wdata !== 32'h0 || mem__wstrb !== 4'h0) begin
         $display("FAIL reset_state: state=%0d busy=%b done=%b fault=%b ld=%h req=%b we=%b addr=%h wd=%h ws=%b, want all 0",
                  dbg_state, ls_busy, ls_done, ls_fault, load_data, mem__req, mem__we, mem__addr,
                  mem__wdata, mem__wstrb);
         bad++;
      end
   endtask

   task automatic test_loads();
      do_txn("lb",  1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 1'b0, 32'h0, 4'b0000, 1'b0);
      total++;
      if (load_data !== 32'hFFFF_FF80) begin
         $display("FAIL lb_const: got %h want ffffff80", load_data);
         bad++;
      end
      do_txn("lhu", 1'b0, 3'b101, 32'h1002, 32'h0, 32'hBEEF0000, 0, 1'b0, 32'h0, 4'b0000, 1'b0);
      total++;
      if (load_data !== 32'h0000_BEEF) begin
         $display("FAIL lhu_const: got %h want 0000beef", load_data);
         bad++;
      end
      do_txn("lh",  1'b0, 3'b001, 32'h1002, 32'h0, 32'hBEEF0000, 0, 1'b0, 32'h0, 4'b0000, 1'b0);
      total++;
      if (load_data !== 32'hFFFF_BEEF) begin
         $display("FAIL lh_const: got %h want ffffbeef", load_data);
         bad++;
      end
   endtask

   task automatic test_stores();
      do_txn("sb", 1'b1, 3'b000, 32'h2001, 32'h123456AB, 32'h0, 0, 1'b0, 32'hABABABAB, 4'b0010, 1'b0);
      do_txn("sh", 1'b1, 3'b001, 32'h2002, 32'h1234CAFE, 32'h0, 0, 1'b0, 32'hCAFECAFE, 4'b1100, 1'b0);
      do_txn("sw", 1'b1, 3'b010, 32'h2004, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b0);
   endtask

   task automatic test_faults();
      do_txn("lw_mis",   1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 1'b0);
      do_txn("ld_f3_011", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 1'b0);
      do_txn("lh_mis",   1'b0, 3'b001, 32'h1001, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 1'b0);
      do_txn("sh_mis",   1'b1, 3'b001, 32'h2003, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 1'b0);
      do_txn("st_f3_100", 1'b1, 3'b100, 32'h2000, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 1'b0);
   endtask

   task automatic test_wait_states();
      do_txn("lw_wait3", 1'b0, 3'b010, 32'h3000, 32'h0, 32'h13579BDF, 3, 1'b0, 32'h0, 4'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (mem__req !== 1'b0 || ls_done !== 1'b0 || dbg_state !== IDLE) begin
            $display("FAIL busy_start_ignored: cyc%0d req=%b done=%b state=%0d", i, mem__req, ls_done, dbg_state);
            bad++;
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_txn("b2b_ld", 1'b0, 3'b100, 32'h4001, 32'h0, 32'hA5C3E1F7, 0, 1'b0, 32'h0, 4'b0, 1'b0);
      do_txn("b2b_st", 1'b1, 3'b000, 32'h4003, 32'h000000C4, 32'h0, 1, 1'b0, 32'hC4C4C4C4, 4'b1000, 1'b0);
   endtask

   task automatic test_reset_mid_req();
      logic seen_done;
      cfsm__ls_start = 1'b1;
      cfsm__ls_write = 1'b0;
      funct3 = 3'b010;
      addr = 32'h5000;
      mem__ready = 1'b0;
      tick();
      cfsm__ls_start = 1'b0;
      tick();
      total++;
      if (mem__req !== 1'b1 || load_data === 32'h0) begin
         $display("FAIL rst_mid_pre: req=%b ld=%h, want req=1 ld nonzero", mem__req, load_data);
         bad++;
      end
      reset = 1'b1;
      mem__ready = 1'b1;
      mem__rdata = 32'h7777_7777;
      tick();
      reset = 1'b0;
      mem__ready = 1'b0;
      total++;
      if (mem__req !== 1'b0 || dbg_state !== IDLE || load_data !== 32'h0 || ls_done !== 1'b0) begin
         $display("FAIL rst_mid: req=%b state=%0d ld=%h done=%b, want 0/IDLE/0/0", mem__req, dbg_state, load_data, ls_done);
         bad++;
      end
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ls_done === 1'b1 || mem__req === 1'b1) seen_done = 1'b1;
      end
      total++;
      if (seen_done !== 1'b0) begin
         $display("FAIL rst_mid_quiet: done/req seen after reset=%b want 0", seen_done);
         bad++;
      end
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic        we;
      logic [31:0] a, sd, rd, ew;
      logic [3:0]  es;
      int          sel;
      for (int n = 0; n < 12; n++) begin
         we  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, we ? 2 : 4);
         f3  = (sel == 3) ? 3'b100 : (sel == 4) ? 3'b101 : 3'(sel);
         a   = $urandom;
         if (f3[1:0] == 2'b01) a[0] = 1'b0;
         if (f3 == 3'b010) a[1:0] = 2'b00;
         sd  = $urandom;
         rd  = $urandom;
         ew  = 32'h0;
         es  = 4'h0;
         if (we) begin
            case (f3)
               3'b000:  begin ew = sd[7:0] * 32'h01010101; es = 4'(1 << a[1:0]); end
               3'b001:  begin ew = sd[15:0] * 32'h00010001; es = a[1] ? 4'hC : 4'h3; end
               default: begin ew = sd; es = 4'hF; end
            endcase
         end
         do_txn("rand", we, f3, a, sd, rd, $urandom_range(0, 2), 1'b0, ew, es, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_faults();
      test_wait_states();
      test_back_to_back();
      test_reset_mid_req();
      test_random();
      total++;
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
         bad++;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
